// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, controller states, instruction
// classes and datapath select encodings.
package riscv_pkg;

   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_e;

   typedef enum logic [3:0] {
      CLS_OP,
      CLS_OPIMM,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_AUIPC,
      CLS_LUI,
      CLS_NONE
   } instr_class_e;

   localparam logic ALU_A_RS1 = 1'b0;
   localparam logic ALU_A_PC  = 1'b1;
   localparam logic ALU_B_RS2 = 1'b0;
   localparam logic ALU_B_IMM = 1'b1;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/instr_classifier.sv
// Maps a 7-bit opcode onto an instruction class and flags opcodes the core
// does not implement.
import riscv_pkg::*;

module instr_classifier (
   input  logic [6:0]   opcode,
   output instr_class_e cls,
   output logic         legal
);

   always_comb begin
      cls   = CLS_NONE;
      legal = 1'b1;
      case (opcode)
         OPC_OP:     cls = CLS_OP;
         OPC_I:      cls = CLS_OPIMM;
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE:  cls = CLS_STORE;
         OPC_BRANCH: cls = CLS_BRANCH;
         OPC_JAL:    cls = CLS_JAL;
         OPC_JALR:   cls = CLS_JALR;
         OPC_AUIPC:  cls = CLS_AUIPC;
         OPC_LUI:    cls = CLS_LUI;
         default:    legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: owns PC and IR, sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects.
import riscv_pkg::*;

module multicycle_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   input  logic        i_imem_valid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   input  logic        i_dmem_valid,
   input  logic [31:0] i_alu_result,
   input  logic        i_branch_taken,
   output logic [31:0] o_pc,
   output logic [6:0]  o_opcode,
   output logic [4:0]  o_rd,
   output logic [2:0]  o_funct3,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [6:0]  o_funct7,
   output logic        o_alu_a_sel,
   output logic        o_alu_b_sel,
   output logic [1:0]  o_wb_sel,
   output logic        o_rf_we,
   output logic        o_illegal,
   output logic [31:0] o_instret
);

   state_e       state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  instret_q, instret_d;
   logic         illegal_q, illegal_d;
   logic         retire;
   logic [31:0]  pc_plus4;
   instr_class_e cls;
   logic         legal;

   instr_classifier u_classifier (
      .opcode (ir_q[6:0]),
      .cls    (cls),
      .legal  (legal)
   );

   assign pc_plus4 = pc_q + 32'd4;

   // PC and instret only move in the last cycle of an instruction (retire).
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (i_imem_valid) begin
               ir_d    = i_imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d   = legal ? S_EXEC : S_TRAP;
            illegal_d = illegal_q | ~legal;
         end
         S_EXEC: begin
            case (cls)
               CLS_LOAD, CLS_STORE: state_d = S_MEM;
               CLS_BRANCH: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
                  pc_d    = i_branch_taken ? i_alu_result : pc_plus4;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (i_dmem_valid) begin
               if (cls == CLS_LOAD) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
                  pc_d    = pc_plus4;
               end
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
            case (cls)
               CLS_JAL:  pc_d = i_alu_result;
               CLS_JALR: pc_d = {i_alu_result[31:1], 1'b0};
               default:  pc_d = pc_plus4;
            endcase
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
      instret_d = retire ? instret_q + 32'd1 : instret_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         instret_q <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
      end
   end

   // Selects are decoded from the IR class; they only matter in EXEC/WB.
   always_comb begin
      o_alu_a_sel = ALU_A_RS1;
      o_alu_b_sel = ALU_B_IMM;
      o_wb_sel    = WB_ALU;
      case (cls)
         CLS_OP:     o_alu_b_sel = ALU_B_RS2;
         CLS_LOAD:   o_wb_sel    = WB_MEM;
         CLS_JALR:   o_wb_sel    = WB_PC4;
         CLS_LUI:    o_wb_sel    = WB_IMM;
         CLS_BRANCH: o_alu_a_sel = ALU_A_PC;
         CLS_AUIPC:  o_alu_a_sel = ALU_A_PC;
         CLS_JAL: begin
            o_alu_a_sel = ALU_A_PC;
            o_wb_sel    = WB_PC4;
         end
         default: ;
      endcase
   end

   // Requests and enables are gated by reset so an abort drops them at once.
   assign o_imem_req = (state_q == S_FETCH) & ~i_rst;
   assign o_dmem_req = (state_q == S_MEM) & ~i_rst;
   assign o_dmem_we  = (state_q == S_MEM) & (cls == CLS_STORE) & ~i_rst;
   assign o_rf_we    = (state_q == S_WB) & (ir_q[11:7] != 5'd0) & ~i_rst;

   assign o_pc      = pc_q;
   assign o_instret = instret_q;
   assign o_illegal = illegal_q;
   assign o_opcode  = ir_q[6:0];
   assign o_rd      = ir_q[11:7];
   assign o_funct3  = ir_q[14:12];
   assign o_rs1     = ir_q[19:15];
   assign o_rs2     = ir_q[24:20];
   assign o_funct7  = ir_q[31:25];

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a driver issues instructions and
// pushes expected retirement results; a monitor checks each retired instruction.
module tb_multicycle_controller;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic        i_imem_valid = 1'b0;
   logic [31:0] i_imem_rdata = 32'd0;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic        i_dmem_valid = 1'b0;
   logic [31:0] i_alu_result = 32'd0;
   logic        i_branch_taken = 1'b0;
   logic [31:0] o_pc;
   logic [6:0]  o_opcode;
   logic [4:0]  o_rd;
   logic [2:0]  o_funct3;
   logic [4:0]  o_rs1;
   logic [4:0]  o_rs2;
   logic [6:0]  o_funct7;
   logic        o_alu_a_sel;
   logic        o_alu_b_sel;
   logic [1:0]  o_wb_sel;
   logic        o_rf_we;
   logic        o_illegal;
   logic [31:0] o_instret;

   multicycle_controller #(.RESET_PC(RST_PC)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .o_imem_req     (o_imem_req),
      .i_imem_valid   (i_imem_valid),
      .i_imem_rdata   (i_imem_rdata),
      .o_dmem_req     (o_dmem_req),
      .o_dmem_we      (o_dmem_we),
      .i_dmem_valid   (i_dmem_valid),
      .i_alu_result   (i_alu_result),
      .i_branch_taken (i_branch_taken),
      .o_pc           (o_pc),
      .o_opcode       (o_opcode),
      .o_rd           (o_rd),
      .o_funct3       (o_funct3),
      .o_rs1          (o_rs1),
      .o_rs2          (o_rs2),
      .o_funct7       (o_funct7),
      .o_alu_a_sel    (o_alu_a_sel),
      .o_alu_b_sel    (o_alu_b_sel),
      .o_wb_sel       (o_wb_sel),
      .o_rf_we        (o_rf_we),
      .o_illegal      (o_illegal),
      .o_instret      (o_instret)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] npc;
      logic [31:0] instret;
      int          cycles;
      int          rfwe;
      logic [1:0]  wbsel;
      int          dmem;
      bit          store;
      bit          chk_sel;
      logic        a_sel;
      logic        b_sel;
      logic [6:0]  opc;
      int          exec_idx;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] pc_model = RST_PC;
   logic [31:0] instret_model = 32'd0;
   int          dmem_wait = 0;
   bit          mon_en = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: expected retirement behaviour from the opcode alone.
   function automatic bit model(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                                input logic taken, input int iw, input int dw, output exp_t e);
      int  base;
      bit  wr;
      bit  mem;
      base = 4; wr = 1; mem = 0;
      e.npc = pc + 32'd4; e.wbsel = 2'd0; e.store = 0; e.chk_sel = 1;
      e.a_sel = 1'b0; e.b_sel = 1'b1; e.opc = instr[6:0];
      case (instr[6:0])
         7'h33: e.b_sel = 1'b0;
         7'h13: ;
         7'h03: begin base = 5; mem = 1; e.wbsel = 2'd1; end
         7'h23: begin wr = 0; mem = 1; e.store = 1; end
         7'h63: begin base = 3; wr = 0; e.a_sel = 1'b1; if (taken) e.npc = alu; end
         7'h6F: begin e.a_sel = 1'b1; e.wbsel = 2'd2; e.npc = alu; end
         7'h67: begin e.wbsel = 2'd2; e.npc = alu & 32'hFFFF_FFFE; end
         7'h17: e.a_sel = 1'b1;
         7'h37: begin e.wbsel = 2'd3; e.chk_sel = 0; end
         default: return 0;
      endcase
      e.cycles   = base + iw + (mem ? dw : 0);
      e.rfwe     = (wr && instr[11:7] != 5'd0) ? 1 : 0;
      e.dmem     = mem ? dw + 1 : 0;
      e.exec_idx = iw + 2;
      e.instret  = instret_model + 32'd1;
      return 1;
   endfunction

   task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] alu, input logic taken,
                                 input int iw, input int dw, input bit push);
      exp_t e;
      int   n;
      n = 0;
      @(negedge i_clk);
      while (!o_imem_req && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_imem_req) begin
         check_output("imem_req_timeout", {31'd0, o_imem_req}, 32'd1);
         return;
      end
      if (model(instr, pc_model, alu, taken, iw, dw, e)) begin
         if (push) exp_q.push_back(e);
         pc_model      = e.npc;
         instret_model = e.instret;
      end
      repeat (iw) @(negedge i_clk);
      i_imem_rdata   = instr;
      i_alu_result   = alu;
      i_branch_taken = taken;
      dmem_wait      = dw;
      i_imem_valid   = 1'b1;
      @(negedge i_clk);
      i_imem_valid   = 1'b0;
   endtask

   // Data memory responder: completes each access after the chosen wait.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_dmem_req && !i_rst) begin
            repeat (dmem_wait) @(negedge i_clk);
            i_dmem_valid = 1'b1;
            @(negedge i_clk);
            i_dmem_valid = 1'b0;
         end
      end
   end

   logic       prev_req = 1'b0;
   bit         active = 1'b0;
   int         cyc, rfwe_cnt, dmem_cnt, dmem_we_cnt;
   logic [1:0] wbsel_seen;
   logic       asel_log[$];
   logic       bsel_log[$];
   logic [6:0] opc_log[$];

   task automatic finish_instr();
      exp_t e;
      if (exp_q.size() == 0) begin
         check_output("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check_output("pc", o_pc, e.npc);
      check_output("instret", o_instret, e.instret);
      check_output("cycles", cyc, e.cycles);
      check_output("rf_we_cycles", rfwe_cnt, e.rfwe);
      if (e.rfwe != 0) check_output("wb_sel", {30'd0, wbsel_seen}, {30'd0, e.wbsel});
      check_output("dmem_req_cycles", dmem_cnt, e.dmem);
      check_output("dmem_we_cycles", dmem_we_cnt, e.store ? e.dmem : 0);
      if (e.exec_idx < opc_log.size()) begin
         check_output("exec_opcode", {25'd0, opc_log[e.exec_idx]}, {25'd0, e.opc});
         if (e.chk_sel) begin
            check_output("alu_a_sel", {31'd0, asel_log[e.exec_idx]}, {31'd0, e.a_sel});
            check_output("alu_b_sel", {31'd0, bsel_log[e.exec_idx]}, {31'd0, e.b_sel});
         end
      end else begin
         check_output("exec_index", e.exec_idx, opc_log.size());
      end
   endtask

   // Monitor: a rising fetch request marks the end of the previous instruction.
   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_imem_req && !prev_req) begin
            if (active) finish_instr();
            active = 1'b1;
            cyc = 0; rfwe_cnt = 0; dmem_cnt = 0; dmem_we_cnt = 0; wbsel_seen = 2'd0;
            asel_log.delete(); bsel_log.delete(); opc_log.delete();
         end
         if (active) begin
            cyc++;
            if (o_rf_we) begin
               rfwe_cnt++;
               wbsel_seen = o_wb_sel;
            end
            if (o_dmem_req) begin
               dmem_cnt++;
               if (o_dmem_we) dmem_we_cnt++;
            end
            asel_log.push_back(o_alu_a_sel);
            bsel_log.push_back(o_alu_b_sel);
            opc_log.push_back(o_opcode);
         end
         prev_req = o_imem_req;
      end else begin
         active = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0]  opcs [0:8];
      logic [31:0] instr;
      int          n;
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37};

      repeat (3) @(negedge i_clk);
      check_output("rst_imem_req", {31'd0, o_imem_req}, 32'd0);
      check_output("rst_dmem_req", {31'd0, o_dmem_req}, 32'd0);
      check_output("rst_rf_we", {31'd0, o_rf_we}, 32'd0);
      check_output("rst_pc", o_pc, RST_PC);
      check_output("rst_instret", o_instret, 32'd0);
      check_output("rst_illegal", {31'd0, o_illegal}, 32'd0);

      mon_en = 1'b1;
      @(posedge i_clk);
      #2 i_rst = 1'b0;

      apply_stimulus(32'h0050_0093, 32'd5, 1'b0, 0, 0, 1);
      apply_stimulus(32'h0020_8033, 32'd7, 1'b0, 0, 0, 1);
      apply_stimulus(32'h0000_A283, 32'h40, 1'b0, 0, 3, 1);
      apply_stimulus(32'h0000_00EF, 32'h200, 1'b0, 1, 0, 1);
      apply_stimulus(32'h0000_0063, 32'h1F0, 1'b1, 0, 0, 1);
      apply_stimulus(32'h0000_006F, 32'h200, 1'b0, 0, 0, 1);
      apply_stimulus(32'h0000_0063, 32'h1F0, 1'b0, 0, 0, 1);
      apply_stimulus(32'h0001_00E7, 32'h301, 1'b0, 2, 0, 1);
      apply_stimulus(32'h0020_A023, 32'h80, 1'b0, 0, 2, 1);
      apply_stimulus(32'h0000_006F, 32'hFFFF_FFFC, 1'b0, 0, 0, 1);
      apply_stimulus(32'h0050_0093, 32'd5, 1'b0, 0, 0, 1);

      for (int i = 0; i < 60; i++) begin
         instr = $urandom;
         instr[6:0] = opcs[$urandom_range(8)];
         if ($urandom_range(3) == 0) instr[11:7] = 5'd0;
         apply_stimulus(instr, $urandom, 1'($urandom_range(1)), $urandom_range(2), $urandom_range(3), 1);
      end

      n = 0;
      while (!o_imem_req && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      @(negedge i_clk);
      check_output("scoreboard_drained", exp_q.size(), 32'd0);
      mon_en = 1'b0;

      // Abort a load while its data access is still pending.
      apply_stimulus(32'h0000_A283, 32'h44, 1'b0, 0, 8, 0);
      n = 0;
      while (!o_dmem_req && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      @(negedge i_clk);
      check_output("mem_wait_req", {31'd0, o_dmem_req}, 32'd1);
      #1 i_rst = 1'b1;
      #1;
      check_output("abort_dmem_req", {31'd0, o_dmem_req}, 32'd0);
      check_output("abort_rf_we", {31'd0, o_rf_we}, 32'd0);
      check_output("abort_pc", o_pc, RST_PC);
      check_output("abort_instret", o_instret, 32'd0);
      pc_model = RST_PC;
      instret_model = 32'd0;
      repeat (12) @(negedge i_clk);
      @(posedge i_clk);
      #2 i_rst = 1'b0;
      @(negedge i_clk);
      check_output("post_reset_imem_req", {31'd0, o_imem_req}, 32'd1);

      // One good instruction, then an unknown opcode that must trap.
      apply_stimulus(32'h0050_0093, 32'd5, 1'b0, 0, 0, 0);
      apply_stimulus(32'h0000_007F, 32'h500, 1'b1, 0, 0, 0);
      repeat (2) @(negedge i_clk);
      for (int i = 0; i < 6; i++) begin
         check_output("trap_illegal", {31'd0, o_illegal}, 32'd1);
         check_output("trap_pc", o_pc, pc_model);
         check_output("trap_instret", o_instret, instret_model);
         check_output("trap_imem_req", {31'd0, o_imem_req}, 32'd0);
         check_output("trap_dmem_req", {31'd0, o_dmem_req}, 32'd0);
         check_output("trap_rf_we", {31'd0, o_rf_we}, 32'd0);
         @(negedge i_clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the RV32I core. Owns the PC and instruction register, sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with valid/request handshakes to instruction and data memory, and drives datapath selects, including instruction fields to the immediate generator. Sits between the memory interfaces and the register file/ALU datapath.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- o_imem_req  out  1  instruction fetch request, address = o_pc
- i_imem_valid  in  1  fetch data valid; may assert in the same cycle as request
- i_imem_rdata  in  32  instruction word
- o_dmem_req  out  1  data access request, address = i_alu_result
- o_dmem_we  out  1  store (1) / load (0), valid with o_dmem_req
- i_dmem_valid  in  1  data access complete
- i_alu_result  in  32  ALU output: address or branch/jump target
- i_branch_taken  in  1  branch comparison result, sampled in EXEC
- o_pc  out  32  current PC
- o_opcode/o_rd/o_funct3/o_rs1/o_rs2/o_funct7  out  7/5/3/5/5/7  IR fields to register file and immediate generator
- o_alu_a_sel  out  1  0 = rs1, 1 = PC
- o_alu_b_sel  out  1  0 = rs2, 1 = immediate
- o_wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate
- o_rf_we  out  1  register file write enable
- o_illegal  out  1  sticky illegal-opcode flag
- o_instret  out  32  retired-instruction counter

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - o_imem_req=1 until i_imem_valid.
  - On valid: latch IR, go to DECODE.
- DECODE: one cycle; classify opcode.
  - Unknown opcode: TRAP.
  - Otherwise: EXEC.
- EXEC: selects by class.
  - OP: a=rs1, b=rs2.
  - OP-IMM/LOAD/STORE/JALR: a=rs1, b=imm.
  - BRANCH/JAL/AUIPC: a=PC, b=imm.
- EXEC next state:
  - LOAD/STORE: MEM.
  - BRANCH: FETCH.
  - All others: WB.
- MEM:
  - o_dmem_req=1 until i_dmem_valid; o_dmem_we=1 for STORE.
  - On valid: LOAD goes to WB, STORE goes to FETCH.
- WB: o_rf_we=1 for one cycle unless rd==0; then FETCH.
- wb_sel by class: OP/OP-IMM/AUIPC = ALU; LOAD = mem; JAL/JALR = PC+4; LUI = imm.
- PC update occurs exactly once per instruction, in the final cycle of the instruction:
  - Branch taken: PC ← i_alu_result.
  - Branch not taken: PC ← PC+4.
  - JAL: PC ← i_alu_result.
  - JALR: PC ← {i_alu_result[31:1],1'b0}.
  - All others: PC ← PC+4.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- o_instret increments by 1 on each retirement (final cycle); wraps at 2^32. Never increments in TRAP.
- TRAP:
  - o_illegal=1; all requests and enables 0.
  - Held until reset. PC frozen at the faulting instruction.

## Timing
- Reset values:
  - State = FETCH, o_pc = RESET_PC, IR = 0, o_instret = 0, o_illegal = 0.
  - o_imem_req, o_dmem_req, o_dmem_we, o_rf_we = 0 while i_rst is high.
- Outputs are Moore-decoded from state and IR. o_imem_req rises in the first cycle after reset deasserts.
- Cycle counts with zero-wait memory: OP/OP-IMM/LUI/AUIPC/JAL/JALR = 4; LOAD = 5; STORE = 4; BRANCH = 3. Each memory wait cycle adds 1.
- Requests stay high and stable while waiting. No request is issued outside FETCH or MEM.
- i_imem_valid/i_dmem_valid outside FETCH/MEM are ignored.
- Reset mid-operation:
  - Abandons any pending request immediately (asynchronous).
  - No register file write, PC update or instret increment occurs for the aborted instruction.

## Structure
- Shared package riscv_pkg holds:
  - opcode localparams (I, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI, OP);
  - the state enum;
  - alu_a/alu_b/wb_sel encodings.
- One combinational sub-module, instr_classifier: opcode to class plus legal flag.

## Test plan
- Reset RESET_PC=32'h100, zero-wait ADDI x1,x0,5 -> o_imem_req in cycle 1; 4 cycles; rf_we=1, wb_sel=0; o_pc=32'h104; o_instret=1.
- LW with i_dmem_valid delayed 3 cycles -> o_dmem_req high 4 cycles; rf_we only in WB; total 8 cycles.
- BEQ at 32'h200, taken, i_alu_result=32'h1F0 -> 3 cycles; o_pc=32'h1F0.
- Same BEQ not taken -> o_pc=32'h204.
- JALR with i_alu_result=32'h301 -> o_pc=32'h300; wb_sel=2.
- ADD with rd=0 -> o_rf_we never 1.
- Opcode 7'b1111111 -> TRAP after DECODE; o_illegal=1; o_pc and o_instret frozen.
- i_rst asserted during MEM wait -> o_dmem_req drops immediately; o_pc=RESET_PC.
- o_instret at 32'hFFFF_FFFF + one retire -> 0.
